// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding-source selection, load-use bubbles, memory-wait
// stalls and multi-cycle branch flush for the LC-3b pipeline, with a
// memory-wait watchdog and saturating stall/bubble performance counters.
module hazard_ctrl #(
  parameter int REG_W       = 3,
  parameter int NUM_SRC     = 2,
  parameter int NUM_FWD     = 2,
  parameter int FLUSH_LEN   = 2,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_HW = 0,
  localparam int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*REG_W-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_FWD*REG_W-1:0]   dest_addr,
  input  logic [NUM_FWD-1:0]         dest_we,
  input  logic                       mem_read0,
  input  logic                       mem_access0,
  input  logic                       dmem_resp,
  input  logic                       branch_taken,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall_front,
  output logic                       stall_mem,
  output logic                       bubble,
  output logic                       flush,
  output logic                       timeout_err,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int FCNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t                         state, state_next;
  logic [FCNT_W-1:0]              flush_cnt;
  logic [WAIT_W-1:0]              wait_cnt;
  logic [NUM_SRC-1:0][NUM_FWD-1:0] match;
  logic [NUM_SRC*SEL_W-1:0]       sel_raw;
  logic                           load_use;
  logic                           stall_mem_raw;
  logic                           flush_raw;

  // Source/stage comparator matrix, with optional hardwired-zero masking.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        match[i][k] = src_valid[i] & dest_we[k]
                    & (src_addr[i*REG_W +: REG_W] == dest_addr[k*REG_W +: REG_W])
                    & ((ZERO_REG_HW == 0) || (src_addr[i*REG_W +: REG_W] != '0));
      end
    end
  end

  // Youngest matching stage wins: scan oldest to youngest, last hit sticks.
  always_comb begin
    sel_raw  = '0;
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (match[i][k]) sel_raw[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
      end
      load_use = load_use | match[i][0];
    end
    load_use = load_use & mem_read0;
  end

  assign stall_mem_raw = mem_access0 & ~dmem_resp;
  assign flush_raw     = branch_taken | (flush_cnt != '0);

  // Zero-latency control outputs, all forced low while reset is held.
  always_comb begin
    fwd_sel     = '0;
    stall_mem   = 1'b0;
    flush       = 1'b0;
    stall_front = 1'b0;
    bubble      = 1'b0;
    if (!reset) begin
      fwd_sel     = sel_raw;
      stall_mem   = stall_mem_raw;
      flush       = flush_raw;
      stall_front = stall_mem_raw | (load_use & ~flush_raw);
      bubble      = load_use & ~stall_mem_raw & ~flush_raw;
    end
  end

  // Memory-wait FSM next state; it only feeds the watchdog.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (stall_mem_raw) state_next = MEM_WAIT;
      MEM_WAIT: if (dmem_resp)     state_next = RUN;
      default:                     state_next = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Branch flush length counter; frozen while memory stalls the back end.
  always_ff @(posedge clk) begin
    if (reset)                                flush_cnt <= '0;
    else if (branch_taken)                    flush_cnt <= FCNT_W'(FLUSH_LEN - 1);
    else if (flush_cnt != '0 && !stall_mem_raw) flush_cnt <= flush_cnt - FCNT_W'(1);
  end

  // Watchdog: counts consecutive unanswered wait cycles, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (state == MEM_WAIT && !dmem_resp) begin
      if (wait_cnt == WAIT_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
      else                                  wait_cnt    <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      bubble_cnt   <= '0;
    end else begin
      if (stall_front && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      if (bubble && bubble_cnt != '1)        bubble_cnt   <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by randomized traffic,
// two instances (zero register hardwired / not) checked against a reference
// model every cycle.
module tb_hazard_ctrl;

  localparam int REG_W     = 3;
  localparam int NUM_SRC   = 2;
  localparam int NUM_FWD   = 2;
  localparam int FLUSH_LEN = 3;
  localparam int TIMEOUT   = 8;
  localparam int CNT_W     = 4;
  localparam int SEL_W     = $clog2(NUM_FWD + 1);
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                     clk;
  logic                     reset;
  logic [NUM_SRC*REG_W-1:0] src_addr;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_FWD*REG_W-1:0] dest_addr;
  logic [NUM_FWD-1:0]       dest_we;
  logic                     mem_read0, mem_access0, dmem_resp, branch_taken;

  // Index 0: ZERO_REG_HW=1, index 1: ZERO_REG_HW=0.
  logic [NUM_SRC*SEL_W-1:0] fwd_sel      [2];
  logic                     stall_front  [2];
  logic                     stall_mem    [2];
  logic                     bubble       [2];
  logic                     flush        [2];
  logic                     timeout_err  [2];
  logic [CNT_W-1:0]         stall_cycles [2];
  logic [CNT_W-1:0]         bubble_cnt   [2];

  for (genvar z = 0; z < 2; z++) begin : g_dut
    hazard_ctrl #(
      .REG_W(REG_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .FLUSH_LEN(FLUSH_LEN),
      .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .ZERO_REG_HW((z == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset), .src_addr(src_addr), .src_valid(src_valid),
      .dest_addr(dest_addr), .dest_we(dest_we), .mem_read0(mem_read0),
      .mem_access0(mem_access0), .dmem_resp(dmem_resp), .branch_taken(branch_taken),
      .fwd_sel(fwd_sel[z]), .stall_front(stall_front[z]), .stall_mem(stall_mem[z]),
      .bubble(bubble[z]), .flush(flush[z]), .timeout_err(timeout_err[z]),
      .stall_cycles(stall_cycles[z]), .bubble_cnt(bubble_cnt[z])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared;
  int mismatched;

  // Reference model state.
  int m_flush_left;   // extra flush cycles still owed
  bit m_in_wait;      // inside a memory-wait episode
  int m_waited;       // unanswered cycles in the current wait episode
  bit m_err;
  int m_stall [2];
  int m_bub   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First (youngest) stage whose destination equals the source, 0 if none.
  function automatic int ref_sel(input int i, input bit zero_hw);
    logic [REG_W-1:0] s;
    s = src_addr[i*REG_W +: REG_W];
    if (!src_valid[i]) return 0;
    if (zero_hw && s == 0) return 0;
    for (int k = 0; k < NUM_FWD; k++)
      if (dest_we[k] && dest_addr[k*REG_W +: REG_W] == s) return k + 1;
    return 0;
  endfunction

  // Check the current cycle against the model, advance the model, go to the
  // next negative edge where the caller drives new inputs.
  task automatic step();
    bit e_smem, e_flush;
    bit e_front [2];
    bit e_bub   [2];
    #1;
    e_smem  = !reset && mem_access0 && !dmem_resp;
    e_flush = !reset && (branch_taken || m_flush_left > 0);
    for (int z = 0; z < 2; z++) begin
      logic [NUM_SRC*SEL_W-1:0] e_sel;
      bit lu;
      int s;
      e_sel = '0;
      lu    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        s = ref_sel(i, z == 0);
        if (s == 1) lu = 1'b1;
        e_sel[i*SEL_W +: SEL_W] = SEL_W'(s);
      end
      lu = lu && mem_read0 && !reset;
      if (reset) e_sel = '0;
      e_front[z] = e_smem || (lu && !e_flush);
      e_bub[z]   = lu && !e_smem && !e_flush;
      check($sformatf("fwd_sel[%0d]", z),      32'(fwd_sel[z]),      32'(e_sel));
      check($sformatf("stall_front[%0d]", z),  32'(stall_front[z]),  32'(e_front[z]));
      check($sformatf("stall_mem[%0d]", z),    32'(stall_mem[z]),    32'(e_smem));
      check($sformatf("bubble[%0d]", z),       32'(bubble[z]),       32'(e_bub[z]));
      check($sformatf("flush[%0d]", z),        32'(flush[z]),        32'(e_flush));
      check($sformatf("timeout_err[%0d]", z),  32'(timeout_err[z]),  32'(m_err));
      check($sformatf("stall_cycles[%0d]", z), 32'(stall_cycles[z]), 32'(m_stall[z]));
      check($sformatf("bubble_cnt[%0d]", z),   32'(bubble_cnt[z]),   32'(m_bub[z]));
    end
    if (reset) begin
      m_flush_left = 0; m_in_wait = 0; m_waited = 0; m_err = 0;
      m_stall = '{0, 0}; m_bub = '{0, 0};
    end else begin
      for (int z = 0; z < 2; z++) begin
        if (e_front[z] && m_stall[z] < CNT_MAX) m_stall[z]++;
        if (e_bub[z] && m_bub[z] < CNT_MAX)     m_bub[z]++;
      end
      if (branch_taken)                    m_flush_left = FLUSH_LEN - 1;
      else if (m_flush_left > 0 && !e_smem) m_flush_left--;
      if (m_in_wait) begin
        if (dmem_resp) begin
          m_in_wait = 0; m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited >= TIMEOUT) m_err = 1;
        end
      end else if (e_smem) begin
        m_in_wait = 1; m_waited = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    src_addr = '0; src_valid = '0; dest_addr = '0; dest_we = '0;
    mem_read0 = 0; mem_access0 = 0; dmem_resp = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    compared = 0; mismatched = 0;
    m_flush_left = 0; m_in_wait = 0; m_waited = 0; m_err = 0;
    m_stall = '{0, 0}; m_bub = '{0, 0};
    idle();
    reset = 1'b1;
    @(negedge clk);

    // Reset forces the combinational outputs low despite active inputs.
    mem_read0 = 1; mem_access0 = 1; branch_taken = 1;
    src_addr = {3'd2, 3'd2}; src_valid = 2'b11; dest_addr = {3'd2, 3'd2}; dest_we = 2'b11;
    #1;
    check("rst_stall_front", 32'(stall_front[0]), 0);
    check("rst_flush", 32'(flush[0]), 0);
    step();
    do_reset();

    // Forwarding priority.
    src_addr = {3'd0, 3'd3}; src_valid = 2'b01; dest_addr = {3'd3, 3'd3}; dest_we = 2'b11;
    #1 check("fwd_youngest", 32'(fwd_sel[0][SEL_W-1:0]), 1);
    step();
    dest_we = 2'b10;
    #1 check("fwd_older", 32'(fwd_sel[0][SEL_W-1:0]), 2);
    step();
    src_valid = 2'b00;
    #1 check("fwd_invalid", 32'(fwd_sel[0][SEL_W-1:0]), 0);
    step();

    // Load-use with three memory-wait cycles.
    do_reset();
    mem_read0 = 1; mem_access0 = 1; dmem_resp = 0;
    dest_addr = {3'd0, 3'd2}; dest_we = 2'b01; src_addr = {3'd2, 3'd5}; src_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lu_wait_front", 32'(stall_front[0]), 1);
      check("lu_wait_mem", 32'(stall_mem[0]), 1);
      step();
    end
    dmem_resp = 1;
    #1;
    check("lu_resp_mem", 32'(stall_mem[0]), 0);
    check("lu_resp_front", 32'(stall_front[0]), 1);
    check("lu_resp_bubble", 32'(bubble[0]), 1);
    step();
    idle();
    dest_addr = {3'd2, 3'd6}; dest_we = 2'b10; src_addr = {3'd2, 3'd5}; src_valid = 2'b10;
    #1;
    check("lu_after_fwd1", 32'(fwd_sel[0][2*SEL_W-1:SEL_W]), 2);
    check("lu_after_front", 32'(stall_front[0]), 0);
    check("lu_bubble_cnt", 32'(bubble_cnt[0]), 1);
    check("lu_stall_cycles", 32'(stall_cycles[0]), 4);
    step();

    // Flush length, extended by a memory stall.
    do_reset();
    branch_taken = 1;
    #1 check("flush_c0", 32'(flush[0]), 1);
    step();
    branch_taken = 0; mem_access0 = 1; dmem_resp = 0;
    #1 check("flush_c1", 32'(flush[0]), 1);
    step();
    mem_access0 = 0; dmem_resp = 1;
    #1 check("flush_c2", 32'(flush[0]), 1);
    step();
    dmem_resp = 0;
    #1 check("flush_c3", 32'(flush[0]), 1);
    step();
    #1 check("flush_c4", 32'(flush[0]), 0);
    step();

    // Branch and load-use in the same cycle.
    do_reset();
    branch_taken = 1; mem_read0 = 1; mem_access0 = 1; dmem_resp = 1;
    dest_addr = {3'd0, 3'd2}; dest_we = 2'b01; src_addr = {3'd2, 3'd0}; src_valid = 2'b10;
    #1;
    check("br_lu_flush", 32'(flush[0]), 1);
    check("br_lu_bubble", 32'(bubble[0]), 0);
    check("br_lu_front", 32'(stall_front[0]), 0);
    step();

    // Watchdog.
    do_reset();
    mem_access0 = 1; dmem_resp = 0;
    for (int c = 0; c < 9; c++) begin
      #1 check("wd_not_yet", 32'(timeout_err[0]), 0);
      step();
    end
    #1 check("wd_set", 32'(timeout_err[0]), 1);
    step();
    dmem_resp = 1;
    step();
    idle();
    step();
    #1 check("wd_sticky", 32'(timeout_err[0]), 1);
    step();
    reset = 1;
    step();
    reset = 0;
    #1 check("wd_cleared", 32'(timeout_err[0]), 0);
    step();

    // Stall counter saturation.
    do_reset();
    mem_access0 = 1; dmem_resp = 0;
    for (int c = 0; c < 20; c++) step();
    mem_access0 = 0; dmem_resp = 1;
    #1 check("stall_sat", 32'(stall_cycles[0]), CNT_MAX);
    step();

    // Hardwired register 0.
    do_reset();
    src_addr = '0; src_valid = 2'b01; dest_addr = '0; dest_we = 2'b01;
    #1;
    check("zero_hw_on", 32'(fwd_sel[0][SEL_W-1:0]), 0);
    check("zero_hw_off", 32'(fwd_sel[1][SEL_W-1:0]), 1);
    step();

    // Randomized traffic with a small register space to force collisions.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_SRC; i++) src_addr[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
      for (int k = 0; k < NUM_FWD; k++) dest_addr[k*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
      src_valid    = NUM_SRC'($urandom);
      dest_we      = NUM_FWD'($urandom);
      mem_read0    = ($urandom_range(0, 2) == 0);
      mem_access0  = mem_read0 | ($urandom_range(0, 3) == 0);
      dmem_resp    = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised forwarding, stall and flush controller for the LC-3b pipeline; next-generation hazard unit. It compares the EX-stage source registers against the destinations of any number of downstream stages and selects the youngest forwarding source. It also generates load-use bubbles, memory-wait stalls and multi-cycle branch flushes. Watchdog and performance counters make stalls observable.

## Interface
- REG_W, 3, register address width
- NUM_SRC, 2, number of EX-stage source operands
- NUM_FWD, 2, number of forwarding stages; stage 0 = EX/MEM latch (youngest), stage NUM_FWD-1 oldest
- FLUSH_LEN, 2, cycles `flush` stays high per taken branch (≥1)
- TIMEOUT, 256, consecutive memory-wait cycles before `timeout_err`
- CNT_W, 16, performance counter width
- ZERO_REG_HW, 0, 1 = register 0 never matches
- SEL_W (localparam), clog2(NUM_FWD+1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- src_addr  in  NUM_SRC*REG_W  source i at [i*REG_W +: REG_W]
- src_valid  in  NUM_SRC  source i is actually read
- dest_addr  in  NUM_FWD*REG_W  destination of stage k
- dest_we  in  NUM_FWD  stage k writes regfile (load_regfile)
- mem_read0  in  1  stage-0 instruction is a load
- mem_access0  in  1  stage-0 instruction accesses data memory (load or store)
- dmem_resp  in  1  data memory response this cycle
- branch_taken  in  1  taken branch/jump resolved this cycle
- fwd_sel  out  NUM_SRC*SEL_W  per-source select: 0 = regfile, k+1 = stage k
- stall_front  out  1  hold PC, IF/ID, ID/EX
- stall_mem  out  1  hold EX/MEM and MEM/WB
- bubble  out  1  load NOP into EX/MEM
- flush  out  1  squash IF/ID and ID/EX
- timeout_err  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of `stall_front` cycles
- bubble_cnt  out  CNT_W  saturating count of bubbles

## Operation
- Source/stage match: `match(i,k) = src_valid[i] & dest_we[k] & (src_i == dest_k)`.
  - If ZERO_REG_HW=1, the match is additionally masked when src_i == 0.
- `fwd_sel[i]` = k+1 for the lowest matching k; 0 if there is no match. The youngest stage wins.
- `load_use = mem_read0 & |match(i,0)` over all i.
- `stall_mem = mem_access0 & ~dmem_resp`.
- `stall_front = stall_mem | (load_use & ~flush)`.
- `bubble = load_use & ~stall_mem & ~flush`.
  - The load completes and advances while EX holds, so next cycle the load sits at stage 1 and `fwd_sel` = 2.
- FSM states:
  - RUN → MEM_WAIT when `stall_mem`.
  - MEM_WAIT → RUN on `dmem_resp`.
  - `stall_mem` is the same equation in both states; the state is used only for the watchdog.
- Flush:
  - `branch_taken` asserts `flush` combinationally and loads flush_cnt = FLUSH_LEN-1.
  - `flush` = `branch_taken | (flush_cnt != 0)`.
  - flush_cnt decrements only on cycles with `stall_mem` = 0.
  - A new `branch_taken` during a flush reloads the counter.
- Watchdog:
  - wait_cnt increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When wait_cnt reaches TIMEOUT-1 while still waiting, `timeout_err` sets and stays set until reset.
- Perf counters:
  - `stall_cycles` +1 per cycle with `stall_front`=1.
  - `bubble_cnt` +1 per cycle with `bubble`=1.
  - Both saturate at all-ones and do not wrap.

## Timing
- While reset is high: `fwd_sel`, `stall_front`, `stall_mem`, `bubble` and `flush` are forced to 0.
- On the reset edge: state = RUN; flush_cnt, wait_cnt and both perf counters = 0; `timeout_err` = 0.
- Reset mid-wait or mid-flush aborts immediately.
- `fwd_sel`, `stall_*`, `bubble` and the first `flush` cycle are combinational, zero latency.
- Counters and `timeout_err` update on the clock edge ending the qualifying cycle.
- Load-use costs exactly 1 bubble after `dmem_resp`, plus any memory-wait cycles.
- `branch_taken` and a load-use in the same cycle: flush wins; no bubble; `stall_front` = `stall_mem`.

## Test plan
- **Forwarding priority:** src0=R3 valid; dest_we[0]=dest_we[1]=1; both dests=R3 → fwd_sel0=1. Drop dest_we[0] → fwd_sel0=2. src_valid0=0 → fwd_sel0=0.
- **Load-use:** mem_read0=mem_access0=1, dest0=R2, src1=R2, dmem_resp low for 3 cycles then high.
  - Required: stall_front=stall_mem=1 for 3 cycles.
  - Resp cycle: stall_mem=0, stall_front=1, bubble=1.
  - Next cycle (load at stage 1): fwd_sel1=2, no stall; bubble_cnt=1, stall_cycles=4.
- **Flush:** FLUSH_LEN=3, branch_taken pulse at cycle 0 → flush high cycles 0–2. With stall_mem high at cycle 1, flush extends to cycle 3.
- **Flush vs load-use:** same-cycle branch_taken and load_use with dmem_resp=1 → flush=1, bubble=0, stall_front=0.
- **Watchdog:** TIMEOUT=8, mem_access0 held with no resp → timeout_err rises after the 8th wait cycle, stays high after resp, clears only on reset.
- **Counter saturation/ZERO_REG_HW:** CNT_W=4, 20 stall cycles → stall_cycles=15. ZERO_REG_HW=1, src=dest=R0 → fwd_sel=0.
